// File: rtl/cpu_pkg.sv
// Shared CPU definitions: write-back select codes, EX/MEM and MEM/WB field
// positions, and the memory-mapped peripheral window layout.
package cpu_pkg;

  // write-back select codes (2'b11 behaves like WB_ALU)
  localparam logic [1:0] WB_NONE = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_MEM  = 2'b10;

  // EX/MEM bundle layout
  localparam int EXMEM_W         = 73;
  localparam int EXMEM_WB_HI     = 72;
  localparam int EXMEM_WB_LO     = 71;
  localparam int EXMEM_MEM_READ  = 70;
  localparam int EXMEM_MEM_WRITE = 69;
  localparam int EXMEM_RD_HI     = 68;
  localparam int EXMEM_RD_LO     = 64;
  localparam int EXMEM_SDATA_HI  = 63;
  localparam int EXMEM_SDATA_LO  = 32;
  localparam int EXMEM_ADDR_HI   = 31;
  localparam int EXMEM_ADDR_LO   = 0;

  // MEM/WB bundle layout
  localparam int MEMWB_W        = 39;
  localparam int MEMWB_WB_HI    = 38;
  localparam int MEMWB_WB_LO    = 37;
  localparam int MEMWB_RD_HI    = 36;
  localparam int MEMWB_RD_LO    = 32;
  localparam int MEMWB_DATA_HI  = 31;
  localparam int MEMWB_DATA_LO  = 0;

  // peripheral window; offsets are word indices (byte offset >> 2)
  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;
  localparam logic [2:0]  OFF_TH      = 3'd0;  // 0x00
  localparam logic [2:0]  OFF_TL      = 3'd1;  // 0x04
  localparam logic [2:0]  OFF_TCON    = 3'd2;  // 0x08
  localparam logic [2:0]  OFF_LED     = 3'd3;  // 0x0C
  localparam logic [2:0]  OFF_SW      = 3'd4;  // 0x10
  localparam logic [2:0]  OFF_SYSTICK = 3'd5;  // 0x14

  // true when the address falls inside the 32-byte peripheral window
  function automatic logic is_periph(input logic [31:0] addr);
    return addr[31:5] == PERIPH_BASE[31:5];
  endfunction

endpackage

// File: rtl/timer_periph.sv
// Reload timer (TH/TL/TCON), registered timer interrupt and free-running
// systick, with the CPU write port and the read mux for those registers.
module timer_periph
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  offset,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [31:0] th_reg;
  logic [31:0] tl_reg;
  logic [2:0]  tcon_reg;
  logic [31:0] systick_reg;
  logic        irq_reg;

  logic th_we;
  logic tl_we;
  logic tcon_we;
  logic overflow;

  assign th_we    = we && (offset == OFF_TH);
  assign tl_we    = we && (offset == OFF_TL);
  assign tcon_we  = we && (offset == OFF_TCON);
  assign overflow = tcon_reg[0] && (tl_reg == 32'hFFFF_FFFF);

  // timer state; a CPU write to TL or TCON overrides the timer's own update
  // of that cycle, and a TL write also swallows the overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_reg      <= '0;
      tl_reg      <= '0;
      tcon_reg    <= '0;
      systick_reg <= '0;
      irq_reg     <= 1'b0;
    end else begin
      if (th_we) th_reg <= wdata;

      if (tl_we)            tl_reg <= wdata;
      else if (overflow)    tl_reg <= th_reg;
      else if (tcon_reg[0]) tl_reg <= tl_reg + 32'd1;

      if (tcon_we)                                 tcon_reg    <= wdata[2:0];
      else if (overflow && tcon_reg[1] && !tl_we)  tcon_reg[2] <= 1'b1;

      irq_reg     <= tcon_reg[1] & tcon_reg[2];
      systick_reg <= systick_reg + 32'd1;
    end
  end

  // read mux for the registers owned here; other offsets read zero
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_TH:      rdata = th_reg;
      OFF_TL:      rdata = tl_reg;
      OFF_TCON:    rdata = {29'd0, tcon_reg};
      OFF_SYSTICK: rdata = systick_reg;
      default:     rdata = '0;
    endcase
  end

  assign irq = irq_reg;

endmodule

// File: rtl/pipe_mem_memwb.sv
// MEM stage and MEM/WB register: data RAM, peripheral decode, LED register,
// switch synchroniser, load/forward mux and the write-back bundle register.
module pipe_mem_memwb
  import cpu_pkg::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int RAM_AW    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [EXMEM_W-1:0]   exmem,
  input  logic [7:0]           switch_in,
  output logic [MEMWB_W-1:0]   memwb,
  output logic [31:0]          mem_fwd_data,
  output logic [7:0]           led,
  output logic                 irq
);

  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

  logic [1:0]  wb_sel;
  logic        mem_write;
  logic [4:0]  rd;
  logic [31:0] store_data;
  logic [31:0] addr;

  assign wb_sel     = exmem[EXMEM_WB_HI:EXMEM_WB_LO];
  assign mem_write  = exmem[EXMEM_MEM_WRITE];
  assign rd         = exmem[EXMEM_RD_HI:EXMEM_RD_LO];
  assign store_data = exmem[EXMEM_SDATA_HI:EXMEM_SDATA_LO];
  assign addr       = exmem[EXMEM_ADDR_HI:EXMEM_ADDR_LO];

  logic              ram_hit;
  logic              periph_hit;
  logic [2:0]        offset;
  logic [RAM_AW-1:0] ram_idx;

  assign ram_hit    = addr < RAM_BYTES;
  assign periph_hit = is_periph(addr);
  assign offset     = addr[4:2];
  assign ram_idx    = addr[RAM_AW+1:2];

  logic [31:0]        ram [RAM_WORDS];
  logic [31:0]        ram_rdata;
  logic [31:0]        timer_rdata;
  logic [31:0]        load_data;
  logic [7:0]         led_reg;
  logic [7:0]         sw_meta_reg;
  logic [7:0]         sw_sync_reg;
  logic [MEMWB_W-1:0] memwb_reg;
  logic               timer_irq;

  // data RAM write; a store seen while reset is held is dropped
  always_ff @(posedge clk) begin
    if (mem_write && ram_hit && !reset) ram[ram_idx] <= store_data;
  end

  // asynchronous read, so a load sees the pre-store word (read-before-write)
  assign ram_rdata = ram[ram_idx];

  timer_periph u_timer (
    .clk    (clk),
    .reset  (reset),
    .we     (mem_write && periph_hit),
    .offset (offset),
    .wdata  (store_data),
    .rdata  (timer_rdata),
    .irq    (timer_irq)
  );

  // LED register and two-flop switch synchroniser
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_reg     <= '0;
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      if (mem_write && periph_hit && offset == OFF_LED) led_reg <= store_data[7:0];
      sw_meta_reg <= switch_in;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  // load data mux; unmapped addresses read zero
  always_comb begin
    load_data = '0;
    if (ram_hit) begin
      load_data = ram_rdata;
    end else if (periph_hit) begin
      case (offset)
        OFF_LED: load_data = {24'd0, led_reg};
        OFF_SW:  load_data = {24'd0, sw_sync_reg};
        default: load_data = timer_rdata;
      endcase
    end
  end

  assign mem_fwd_data = (wb_sel == WB_MEM) ? load_data : addr;

  // MEM/WB register, loaded every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) memwb_reg <= '0;
    else       memwb_reg <= {wb_sel, rd, mem_fwd_data};
  end

  assign memwb = memwb_reg;
  assign led   = led_reg;
  assign irq   = timer_irq;

endmodule

// File: tb/tb_pipe_mem_memwb.sv
// Randomised bench for pipe_mem_memwb with a behavioural reference model of
// memory, peripherals and timer, plus directed scenarios for the key cases.
module tb_pipe_mem_memwb;

  logic        clk = 1'b0;
  logic        reset;
  logic [72:0] exmem;
  logic [7:0]  switch_in;
  logic [38:0] memwb;
  logic [31:0] mem_fwd_data;
  logic [7:0]  led;
  logic        irq;

  pipe_mem_memwb dut (
    .clk          (clk),
    .reset        (reset),
    .exmem        (exmem),
    .switch_in    (switch_in),
    .memwb        (memwb),
    .mem_fwd_data (mem_fwd_data),
    .led          (led),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [31:0] m_ram [256];
  logic [31:0] m_th, m_tl, m_systick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led, m_sw1, m_sw2;
  logic        m_irq;
  logic [38:0] m_memwb;

  task automatic model_reset();
    m_th = 0; m_tl = 0; m_tcon = 0; m_systick = 0;
    m_led = 0; m_sw1 = 0; m_sw2 = 0; m_irq = 0; m_memwb = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    if (a < 32'd1024) return m_ram[w[7:0]];
    if ((a >> 5) == (32'h4000_0000 >> 5)) begin
      case (w[2:0])
        3'd0: return m_th;
        3'd1: return m_tl;
        3'd2: return {29'd0, m_tcon};
        3'd3: return {24'd0, m_led};
        3'd4: return {24'd0, m_sw2};
        3'd5: return m_systick;
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  function automatic logic [72:0] mk(input logic [1:0] wb, input logic rdf, input logic wrf,
                                     input logic [4:0] rd, input logic [31:0] sd, input logic [31:0] a);
    return {wb, rdf, wrf, rd, sd, a};
  endfunction

  // one cycle: drive at negedge, check forward value, model the edge, check registers
  task automatic step(input logic [72:0] ex);
    logic [31:0] a, sd, ld, fwd, w, n_th, n_tl;
    logic [2:0]  n_tc;
    logic [1:0]  wb;
    logic        wr, pw;
    exmem = ex;
    #2;
    wb = ex[72:71]; wr = ex[69]; sd = ex[63:32]; a = ex[31:0];
    ld  = m_read(a);
    fwd = (wb == 2'b10) ? ld : a;
    check("fwd", {32'd0, mem_fwd_data}, {32'd0, fwd});
    @(posedge clk);
    #1;
    m_memwb = {wb, ex[68:64], fwd};
    w  = a >> 2;
    pw = wr && ((a >> 5) == (32'h4000_0000 >> 5));
    if (wr && a < 32'd1024) m_ram[w[7:0]] = sd;
    n_th = m_th; n_tl = m_tl; n_tc = m_tcon;
    if (m_tcon[0]) begin
      if (m_tl == 32'hFFFF_FFFF) begin
        n_tl = m_th;
        if (m_tcon[1]) n_tc[2] = 1'b1;
      end else begin
        n_tl = m_tl + 1;
      end
    end
    if (pw) begin
      case (w[2:0])
        3'd0: n_th = sd;
        3'd1: begin n_tl = sd; n_tc = m_tcon; end
        3'd2: n_tc = sd[2:0];
        3'd3: m_led = sd[7:0];
        default: ;
      endcase
    end
    m_irq = m_tcon[1] & m_tcon[2];
    m_th = n_th; m_tl = n_tl; m_tcon = n_tc;
    m_systick = m_systick + 1;
    m_sw2 = m_sw1; m_sw1 = switch_in;
    check("memwb", {25'd0, memwb}, {25'd0, m_memwb});
    check("led", {56'd0, led}, {56'd0, m_led});
    check("irq", {63'd0, irq}, {63'd0, m_irq});
    @(negedge clk);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    step(mk(2'b00, 1'b0, 1'b1, 5'd0, d, a));
  endtask

  task automatic ldw(input logic [31:0] a, input logic [4:0] rd);
    step(mk(2'b10, 1'b1, 1'b0, rd, 32'd0, a));
  endtask

  task automatic bub();
    step('0);
  endtask

  localparam logic [31:0] P_TH   = 32'h4000_0000;
  localparam logic [31:0] P_TL   = 32'h4000_0004;
  localparam logic [31:0] P_TCON = 32'h4000_0008;
  localparam logic [31:0] P_LED  = 32'h4000_000C;
  localparam logic [31:0] P_SW   = 32'h4000_0010;

  initial begin
    logic [31:0] a, d, ram0;
    logic [1:0]  wb;
    int          r;

    reset = 1'b1; exmem = '0; switch_in = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_memwb", {25'd0, memwb}, 64'd0);
    check("rst_led", {56'd0, led}, 64'd0);
    check("rst_irq", {63'd0, irq}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // give every RAM word a known value
    for (int i = 0; i < 256; i++) st(32'(i) << 2, $urandom);

    // store then load back through the MEM/WB register
    st(32'h10, 32'hDEAD_BEEF);
    ldw(32'h10, 5'd5);
    check("t1_load", {25'd0, memwb}, {25'd0, 2'b10, 5'd5, 32'hDEAD_BEEF});

    // out-of-range load reads zero, store is dropped (no aliasing onto word 0)
    ram0 = m_ram[0];
    ldw(32'h800, 5'd1);
    check("t2_oob_load", {32'd0, memwb[31:0]}, 64'd0);
    st(32'h800, 32'h1111_2222);
    ldw(32'h0, 5'd2);
    check("t2_ram_kept", {32'd0, memwb[31:0]}, {32'd0, ram0});

    // reload timer with interrupt
    st(P_TH, 32'hFFFF_FFFE);
    st(P_TL, 32'hFFFF_FFFE);
    st(P_TCON, 32'd3);
    bub(); bub(); bub();
    check("t3_irq_set", {63'd0, irq}, 64'd1);
    st(P_TCON, 32'd3);
    bub();
    check("t3_irq_clr", {63'd0, irq}, 64'd0);
    st(P_TCON, 32'd0);

    // CPU write to TL beats the overflow in the same cycle
    st(P_TH, 32'h100);
    st(P_TL, 32'hFFFF_FFFE);
    st(P_TCON, 32'd3);
    bub();
    st(P_TL, 32'd5);
    ldw(P_TL, 5'd3);
    check("t4_tl", {32'd0, memwb[31:0]}, 64'd5);
    ldw(P_TCON, 5'd4);
    check("t4_tcon", {32'd0, memwb[31:0]}, 64'd3);
    st(P_TCON, 32'd0);

    // ALU result forwarding and write-back
    exmem = mk(2'b01, 1'b0, 1'b0, 5'd9, 32'd0, 32'h1234);
    #2;
    check("t5_fwd", {32'd0, mem_fwd_data}, 64'h1234);
    step(mk(2'b01, 1'b0, 1'b0, 5'd9, 32'd0, 32'h1234));
    check("t5_memwb", {25'd0, memwb}, {25'd0, 2'b01, 5'd9, 32'h1234});

    // synchronised switches
    switch_in = 8'hA5;
    bub(); bub(); bub();
    ldw(P_SW, 5'd6);
    check("t6_sw", {32'd0, memwb[31:0]}, 64'hA5);

    // reset in the middle of timer activity; the store under reset is dropped
    st(P_LED, 32'h3C);
    st(P_TCON, 32'd3);
    bub();
    #2;
    reset = 1'b1;
    exmem = mk(2'b00, 1'b0, 1'b1, 5'd0, 32'hCAFE_F00D, 32'h20);
    #1;
    check("t6_rst_led", {56'd0, led}, 64'd0);
    check("t6_rst_irq", {63'd0, irq}, 64'd0);
    check("t6_rst_memwb", {25'd0, memwb}, 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ldw(P_TL, 5'd7);
    check("t6_rst_tl", {32'd0, memwb[31:0]}, 64'd0);
    ldw(32'h20, 5'd8);
    check("t6_store_dropped", {32'd0, memwb[31:0]}, {32'd0, m_ram[8]});

    // randomised traffic
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 9);
      if (r < 5)       a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
      else if (r < 8)  a = 32'h4000_0000 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      else if (r == 8) a = 32'h400 + 32'($urandom_range(0, 32'h3FF));
      else             a = $urandom;
      d  = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      wb = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) switch_in = 8'($urandom);
      step(mk(wb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), d, a));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
